exec_controller: RTL
====================

# exec_controller

Execution sequencer for the single-cycle processor datapath (PC, instruction memory, register file, ULA). It decides on which clock edges the program counter advances and the register file may be written. It supports free-run at a divided rate, single-step, halt and one PC breakpoint, and it counts retired instructions for display. It sits between the board keys/switches and the PC/register-file enables; the datapath's own control unit still decodes instructions.

## Interface
- TICK_DIV, 50_000_000: clock cycles per instruction in RUN (min 2)
- PC_WIDTH, 8: width of PC and breakpoint address
- CNT_WIDTH, 16: width of retired-instruction counter
- clock_reg  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- run_req  in  1  level, synchronous; rising edge requests RUN
- step_req  in  1  level, synchronous; rising edge requests one instruction
- halt_req  in  1  level, synchronous; rising edge requests HALT
- bp_en  in  1  breakpoint enable
- bp_addr  in  PC_WIDTH  breakpoint PC value
- pc  in  PC_WIDTH  current PC from the program counter
- regwrite_in  in  1  RegWrite from the control unit
- pc_en  out  1  PC loads PC+4 at the next rising edge
- reg_we  out  1  gated register-file write enable
- state  out  2  IDLE=00, RUN=01, STEP=10, HALT=11
- halted  out  1  high when state==HALT
- retired  out  CNT_WIDTH  instructions committed since reset

## Operation
- **Edge detection**
  - Each request input has its own previous-value register, reset to 0.
  - A request's edge is high in the cycle where the input is 1 and its previous value is 0.
- **Edge priority** (when more than one edge is present in the same cycle): halt > run > step. Lower-priority edges in that cycle are discarded.
- **FSM transitions**
  - IDLE: run edge -> RUN; step edge -> STEP; halt edge -> HALT.
  - HALT: run edge -> RUN; step edge -> STEP.
  - RUN: halt edge -> HALT; breakpoint hit -> HALT; run and step edges ignored.
  - STEP: always -> HALT after one cycle; all edges in STEP are ignored.
- **Divider**
  - Counter `div` is cleared on entry to RUN, then counts 0..TICK_DIV-1 and wraps to 0.
  - tick = RUN && div==TICK_DIV-1.
- **Breakpoint**
  - bp_hit = tick && bp_en && pc==bp_addr && !first.
  - `first` is set on entry to RUN and cleared at the first tick. This lets RUN resume from the breakpoint PC.
- **Combinational outputs**
  - pc_en = (state==STEP) | (tick & ~bp_hit & ~halt_edge).
  - reg_we = regwrite_in & pc_en. The register file never writes while the PC is frozen.
- **Retired counter**
  - retired increments by 1 on each cycle with pc_en=1.
  - It saturates at all-ones and never wraps.

## Timing
- **Reset values** (immediate on reset low, independent of clock): state=IDLE, halted=0, retired=0, div=0, first=0, edge registers=0. pc_en=0 and reg_we=0 follow from state.
- **Step latency:** step_req rises before edge k. Edge k enters STEP. pc_en=1 for exactly one cycle. The PC advances at edge k+1. state=HALT after edge k+1.
- **Run cadence:** run edge sampled at edge k enters RUN with div=0. The first pc_en occurs TICK_DIV cycles later, then one pulse every TICK_DIV cycles.
- **Halt coinciding with tick:** pc_en is suppressed and the PC does not advance.
- **Breakpoint:** the instruction at bp_addr is not executed (no pc_en, no reg_we). HALT takes effect at the next edge.
- **Reset mid-RUN or mid-STEP:** no further pc_en pulses; the controller returns to IDLE.
- pc_en is never high for two consecutive cycles when TICK_DIV >= 2.

## Test plan
- **Reset:** assert reset mid-RUN with div=2 -> state=00, retired=0, pc_en=0 immediately; stays IDLE after release.
- **Single step** (TICK_DIV=4): from IDLE, pulse step_req, held high 3 cycles.
  - Expect exactly one pc_en pulse, retired=1, state=11.
  - Holding step_req high must not cause a second step.
- **Run cadence** (TICK_DIV=4): run edge then 12 cycles -> pc_en on cycles 4, 8, 12 after entry; retired=3.
- **Breakpoint:** bp_en=1, bp_addr=0x0C, pc model starting at 0 and advancing by 4 on pc_en.
  - RUN halts with pc=0x0C and retired=3.
  - A second run edge advances to pc=0x10 at the next tick (first-tick exemption).
- **Simultaneous edges and halt-at-tick:**
  - halt and run edges in the same cycle from IDLE -> HALT.
  - halt edge on a tick cycle in RUN -> pc_en=0, PC unchanged.
- **Write gating and saturation:**
  - regwrite_in=1 held while HALT -> reg_we stays 0.
  - CNT_WIDTH=4 with 20 steps -> retired=15.

Source files
------------

// File: rtl/exec_controller.sv
// Execution sequencer for the single-cycle datapath: gates PC advance and register-file
// writes for free-run (divided), single-step, halt and a single PC breakpoint.
module exec_controller #(
    parameter int unsigned TICK_DIV  = 50_000_000,
    parameter int unsigned PC_WIDTH  = 8,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clock_reg,
    input  logic                 reset,
    input  logic                 run_req,
    input  logic                 step_req,
    input  logic                 halt_req,
    input  logic                 bp_en,
    input  logic [PC_WIDTH-1:0]  bp_addr,
    input  logic [PC_WIDTH-1:0]  pc,
    input  logic                 regwrite_in,
    output logic                 pc_en,
    output logic                 reg_we,
    output logic [1:0]           state,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] retired
);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] STEP = 2'b10;
    localparam logic [1:0] HALT = 2'b11;

    localparam int unsigned       DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_MAX = DIV_W'(TICK_DIV - 1);

    logic             run_prev;
    logic             step_prev;
    logic             halt_prev;
    logic             run_edge;
    logic             step_edge;
    logic             halt_edge;
    logic [1:0]       state_nx;
    logic [DIV_W-1:0] div;
    logic             first;
    logic             tick;
    logic             bp_hit;

    // Lower-priority edges are dropped whenever a higher-priority edge is present.
    always_comb begin
        halt_edge = halt_req & ~halt_prev;
        run_edge  = run_req & ~run_prev & ~halt_edge;
        step_edge = step_req & ~step_prev & ~halt_edge & ~(run_req & ~run_prev);
    end

    assign tick   = (state == RUN) && (div == DIV_MAX);
    assign bp_hit = tick && bp_en && (pc == bp_addr) && !first;
    assign pc_en  = (state == STEP) | (tick & ~bp_hit & ~halt_edge);
    assign reg_we = regwrite_in & pc_en;
    assign halted = (state == HALT);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, HALT: begin
                if (halt_edge)      state_nx = HALT;
                else if (run_edge)  state_nx = RUN;
                else if (step_edge) state_nx = STEP;
            end
            RUN: begin
                if (halt_edge || bp_hit) state_nx = HALT;
            end
            default: state_nx = HALT;
        endcase
    end

    always_ff @(posedge clock_reg or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            run_prev  <= 1'b0;
            step_prev <= 1'b0;
            halt_prev <= 1'b0;
            div       <= '0;
            first     <= 1'b0;
            retired   <= '0;
        end else begin
            state     <= state_nx;
            run_prev  <= run_req;
            step_prev <= step_req;
            halt_prev <= halt_req;

            // 'first' exempts the first tick after entry so RUN can leave a breakpoint PC.
            if (state_nx == RUN && state != RUN) begin
                div   <= '0;
                first <= 1'b1;
            end else begin
                if (state == RUN)
                    div <= (div == DIV_MAX) ? '0 : div + DIV_W'(1);
                if (tick)
                    first <= 1'b0;
            end

            if (pc_en && retired != '1)
                retired <= retired + CNT_WIDTH'(1);
        end
    end

endmodule
